// File: rtl/iter_shifter_pkg.sv
// Constants shared by the iterative and barrel shifters: op codes and FSM states.
package iter_shifter_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_ROL = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-position step of the working register.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] data_i,
  input  logic [1:0]   op_i,
  input  logic         arith_i,
  output logic [W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      SH_SLL:  data_o = {data_i[W-2:0], 1'b0};
      // arith_i is only ever set alongside SRL, so it selects SRA here
      SH_SRL:  data_o = {(arith_i & data_i[W-1]), data_i[W-1:1]};
      SH_ROL:  data_o = {data_i[W-2:0], data_i[W-1]};
      SH_ROR:  data_o = {data_i[0], data_i[W-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit, one bit position per cycle, valid/ready on both sides.
//   state    | meaning
//   ST_IDLE  | waiting for a request, in_ready=1
//   ST_SHIFT | stepping work register, cnt counts remaining steps
//   ST_DONE  | result held on out_data, out_valid=1 until out_ready
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] in_data,
  input  logic [SHAMT_WIDTH-1:0]   sh_amt,
  input  logic [1:0]               sh_oper,
  input  logic                     sh_arith,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = SHAMT_WIDTH'(1);
  localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = '0;

  state_t                     state_q, state_d;
  logic [SHAMT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0]   work_q, work_d;
  logic [1:0]                 op_q, op_d;
  logic                       arith_q, arith_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [OPERAND_WIDTH-1:0]   step_val;

  shift_step #(.W(OPERAND_WIDTH)) u_step (
    .data_i  (work_q),
    .op_i    (op_q),
    .arith_i (arith_q),
    .data_o  (step_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    op_d    = op_q;
    arith_d = arith_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = sh_amt;
          op_d    = sh_oper;
          arith_d = sh_arith & (sh_oper == SH_SRL);
          state_d = (sh_amt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = step_val;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      op_q        <= SH_SLL;
      arith_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      op_q        <= op_d;
      arith_q     <= arith_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule
